// File: rtl/flit_assembler_pkg.sv
// Shared flit layout, error codes and FSM state type for the receive-side
// flit assembler and its checksum accumulator.
package flit_assembler_pkg;

  localparam int PAYLOAD_WIDTH = 30;
  localparam int ID_WIDTH      = 8;

  typedef enum logic [1:0] {
    FLIT_NOPE = 2'b00,
    FLIT_HEAD = 2'b01,
    FLIT_BODY = 2'b10,
    FLIT_TAIL = 2'b11
  } flit_type_t;

  typedef struct packed {
    flit_type_t          ftype;
    logic [ID_WIDTH-1:0] src;
    logic [ID_WIDTH-1:0] dst;
    logic [5:0]          len;
    logic [7:0]          chk;
  } head_flit_t;

  typedef struct packed {
    flit_type_t               ftype;
    logic [PAYLOAD_WIDTH-1:0] payload;
  } data_flit_t;

  typedef union packed {
    head_flit_t head;
    data_flit_t data;
  } flit_t;

  typedef enum logic [2:0] {
    ERR_NONE         = 3'd0,
    ERR_BAD_LEN      = 3'd1,
    ERR_ORPHAN       = 3'd2,
    ERR_UNEXP_HEAD   = 3'd3,
    ERR_EARLY_TAIL   = 3'd4,
    ERR_MISSING_TAIL = 3'd5,
    ERR_CHECKSUM     = 3'd6
  } asm_err_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_HOLD = 2'd2
  } asm_state_t;

  function automatic logic len_in_range(input logic [5:0] len, input int max_len);
    return (len != 6'd0) && (int'(len) <= max_len);
  endfunction

endpackage

// File: rtl/flit_assembler_checksum_acc.sv
// Running XOR of the low payload byte of each data flit; clear wins over enable.
module flit_checksum_acc (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] data,
  output logic [7:0] acc
);

  // accumulator register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= 8'h00;
    end else if (clear) begin
      acc <= 8'h00;
    end else if (enable) begin
      acc <= acc ^ data;
    end
  end

endmodule

// File: rtl/flit_assembler.sv
// Validates HEAD/BODY/TAIL framing, length and checksum of incoming flits and
// presents each good frame as one packet word over a valid/ready handshake.
module flit_assembler
  import flit_assembler_pkg::*;
#(
  parameter int FLIT_WIDTH     = 32,
  parameter int MAX_DATA_FLITS = 4,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [FLIT_WIDTH-1:0]                 flit_in,
  input  logic                                  flit_valid,
  output logic                                  flit_ready,
  output logic                                  pkt_valid,
  input  logic                                  pkt_ready,
  output logic [ID_WIDTH-1:0]                   pkt_src,
  output logic [ID_WIDTH-1:0]                   pkt_dst,
  output logic [2:0]                            pkt_len,
  output logic [MAX_DATA_FLITS*PAYLOAD_WIDTH-1:0] pkt_data,
  output logic                                  err_valid,
  output logic [2:0]                            err_code,
  output logic [DROP_CNT_WIDTH-1:0]             drop_count
);

  flit_t      flit_s;
  asm_state_t state_r;
  asm_state_t state_nxt_s;
  asm_err_t   err_code_s;
  logic       rdy_en_r;
  logic [2:0] idx_r;
  logic [7:0] chk_r;
  logic [7:0] acc_s;
  logic [7:0] xor_s;
  logic       accept_s;
  logic       len_ok_s;
  logic       last_s;
  logic       start_s;
  logic       store_s;
  logic       hold_s;
  logic       err_s;

  assign flit_s     = flit_in;
  assign flit_ready = rdy_en_r && (state_r != ST_HOLD);
  assign accept_s   = flit_valid && flit_ready;
  assign len_ok_s   = len_in_range(flit_s.head.len, MAX_DATA_FLITS);
  assign last_s     = (idx_r == (pkt_len - 3'd1));
  assign xor_s      = acc_s ^ flit_s.data.payload[7:0];

  flit_checksum_acc u_chk (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (start_s),
    .enable (store_s),
    .data   (flit_s.data.payload[7:0]),
    .acc    (acc_s)
  );

  // frame FSM decode: one error at most per cycle, a resync HEAD reports only code 3
  always_comb begin
    state_nxt_s = state_r;
    start_s     = 1'b0;
    store_s     = 1'b0;
    hold_s      = 1'b0;
    err_s       = 1'b0;
    err_code_s  = ERR_NONE;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          case (flit_s.head.ftype)
            FLIT_HEAD: begin
              if (len_ok_s) begin
                start_s     = 1'b1;
                state_nxt_s = ST_RECV;
              end else begin
                err_s      = 1'b1;
                err_code_s = ERR_BAD_LEN;
              end
            end
            FLIT_BODY, FLIT_TAIL: begin
              err_s      = 1'b1;
              err_code_s = ERR_ORPHAN;
            end
            default: begin
              state_nxt_s = ST_IDLE;
            end
          endcase
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RECV: begin
        if (accept_s) begin
          case (flit_s.head.ftype)
            FLIT_HEAD: begin
              err_s      = 1'b1;
              err_code_s = ERR_UNEXP_HEAD;
              if (len_ok_s) begin
                start_s     = 1'b1;
                state_nxt_s = ST_RECV;
              end else begin
                state_nxt_s = ST_IDLE;
              end
            end
            FLIT_BODY: begin
              store_s = 1'b1;
              if (last_s) begin
                err_s       = 1'b1;
                err_code_s  = ERR_MISSING_TAIL;
                state_nxt_s = ST_IDLE;
              end else begin
                state_nxt_s = ST_RECV;
              end
            end
            FLIT_TAIL: begin
              store_s = 1'b1;
              if (!last_s) begin
                err_s       = 1'b1;
                err_code_s  = ERR_EARLY_TAIL;
                state_nxt_s = ST_IDLE;
              end else if (xor_s == chk_r) begin
                hold_s      = 1'b1;
                state_nxt_s = ST_HOLD;
              end else begin
                err_s       = 1'b1;
                err_code_s  = ERR_CHECKSUM;
                state_nxt_s = ST_IDLE;
              end
            end
            default: begin
              state_nxt_s = ST_RECV;
            end
          endcase
        end else begin
          state_nxt_s = ST_RECV;
        end
      end
      ST_HOLD: begin
        if (pkt_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // state, packet assembly and error reporting registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      rdy_en_r   <= 1'b0;
      idx_r      <= 3'd0;
      chk_r      <= 8'h00;
      pkt_valid  <= 1'b0;
      pkt_src    <= '0;
      pkt_dst    <= '0;
      pkt_len    <= 3'd0;
      pkt_data   <= '0;
      err_valid  <= 1'b0;
      err_code   <= 3'd0;
      drop_count <= '0;
    end else begin
      state_r   <= state_nxt_s;
      rdy_en_r  <= 1'b1;
      err_valid <= err_s;
      err_code  <= err_s ? err_code_s : ERR_NONE;
      if (err_s && (drop_count != '1)) begin
        drop_count <= drop_count + DROP_CNT_WIDTH'(1);
      end
      if (start_s) begin
        pkt_src  <= flit_s.head.src;
        pkt_dst  <= flit_s.head.dst;
        pkt_len  <= flit_s.head.len[2:0];
        chk_r    <= flit_s.head.chk;
        pkt_data <= '0;
        idx_r    <= 3'd0;
      end else if (store_s) begin
        pkt_data[PAYLOAD_WIDTH*int'(idx_r) +: PAYLOAD_WIDTH] <= flit_s.data.payload;
        idx_r <= idx_r + 3'd1;
      end
      if (hold_s) begin
        pkt_valid <= 1'b1;
      end else if ((state_r == ST_HOLD) && pkt_ready) begin
        pkt_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_flit_assembler.sv
// Bench for flit_assembler: fixed vector table, corner-case sequences and
// randomized frames checked against a queue-based frame model.
module tb_flit_assembler;

  localparam int MAXF = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  flit_in = 32'h0;
  logic         flit_valid = 1'b0;
  logic         pkt_ready = 1'b0;
  logic         flit_ready, pkt_valid, err_valid;
  logic [7:0]   pkt_src, pkt_dst;
  logic [2:0]   pkt_len, err_code;
  logic [119:0] pkt_data;
  logic [15:0]  drop_count;
  logic         s_flit_ready, s_pkt_valid, s_err_valid;
  logic [7:0]   s_pkt_src, s_pkt_dst;
  logic [2:0]   s_pkt_len, s_err_code;
  logic [119:0] s_pkt_data;
  logic [1:0]   s_drop_count;

  flit_assembler dut (
    .clk(clk), .rst_n(rst_n), .flit_in(flit_in), .flit_valid(flit_valid),
    .flit_ready(flit_ready), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .pkt_src(pkt_src), .pkt_dst(pkt_dst), .pkt_len(pkt_len), .pkt_data(pkt_data),
    .err_valid(err_valid), .err_code(err_code), .drop_count(drop_count)
  );

  flit_assembler #(.DROP_CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .flit_in(flit_in), .flit_valid(flit_valid),
    .flit_ready(s_flit_ready), .pkt_valid(s_pkt_valid), .pkt_ready(pkt_ready),
    .pkt_src(s_pkt_src), .pkt_dst(s_pkt_dst), .pkt_len(s_pkt_len), .pkt_data(s_pkt_data),
    .err_valid(s_err_valid), .err_code(s_err_code), .drop_count(s_drop_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // reference model: frame contents kept as a queue, checksum recomputed at TAIL
  bit           m_rdy_en, m_in_frame, m_hold, m_pv, m_ev, m_last_acc;
  logic [2:0]   m_ec;
  logic [7:0]   m_src, m_dst, m_chk, m_psrc, m_pdst;
  logic [2:0]   m_plen;
  logic [119:0] m_data;
  int           m_len, m_drops;
  logic [29:0]  m_q[$];
  logic [31:0]  sq[$];

  typedef struct {
    logic [31:0] f;
    logic        v;
    logic        pr;
    logic        e_pv;
    logic        e_fr;
    logic        e_ev;
    logic [2:0]  e_ec;
    logic [15:0] e_drop;
  } vec_t;
  vec_t tbl[$];

  function automatic logic [31:0] mk_head(input logic [7:0] s, input logic [7:0] d,
                                          input logic [5:0] l, input logic [7:0] c);
    return {2'b01, s, d, l, c};
  endfunction
  function automatic logic [31:0] mk_body(input logic [29:0] p); return {2'b10, p}; endfunction
  function automatic logic [31:0] mk_tail(input logic [29:0] p); return {2'b11, p}; endfunction
  function automatic logic [31:0] mk_nope(input logic [29:0] p); return {2'b00, p}; endfunction
  function automatic int sat(input int v, input int m); return (v > m) ? m : v; endfunction

  function automatic vec_t mk(input logic [31:0] f, input logic v, input logic pr, input logic e_pv,
                              input logic e_fr, input logic e_ev, input logic [2:0] e_ec,
                              input logic [15:0] e_drop);
    vec_t r;
    r.f = f; r.v = v; r.pr = pr; r.e_pv = e_pv; r.e_fr = e_fr;
    r.e_ev = e_ev; r.e_ec = e_ec; r.e_drop = e_drop;
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_rdy_en = 1'b0; m_in_frame = 1'b0; m_hold = 1'b0; m_pv = 1'b0;
    m_ev = 1'b0; m_ec = 3'd0; m_drops = 0; m_last_acc = 1'b0;
    m_q.delete();
  endtask

  task automatic model_step(input logic [31:0] f, input logic v, input logic pr);
    bit err;
    logic [2:0] code;
    logic [7:0] x;
    err = 1'b0;
    code = 3'd0;
    m_last_acc = v && m_rdy_en && !m_hold;
    if (m_hold) begin
      if (pr) begin
        m_hold = 1'b0;
        m_pv = 1'b0;
      end
    end else if (m_last_acc) begin
      case (f[31:30])
        2'b01: begin
          if (m_in_frame) begin err = 1'b1; code = 3'd3; end
          if (f[13:8] >= 6'd1 && f[13:8] <= 6'(MAXF)) begin
            m_in_frame = 1'b1;
            m_src = f[29:22]; m_dst = f[21:14]; m_len = int'(f[13:8]); m_chk = f[7:0];
            m_q.delete();
          end else begin
            m_in_frame = 1'b0;
            if (!err) begin err = 1'b1; code = 3'd1; end
          end
        end
        2'b10, 2'b11: begin
          if (!m_in_frame) begin
            err = 1'b1; code = 3'd2;
          end else begin
            m_q.push_back(f[29:0]);
            if (f[31:30] == 2'b10) begin
              if (m_q.size() == m_len) begin err = 1'b1; code = 3'd5; m_in_frame = 1'b0; end
            end else if (m_q.size() < m_len) begin
              err = 1'b1; code = 3'd4; m_in_frame = 1'b0;
            end else begin
              x = 8'h00;
              foreach (m_q[i]) x ^= m_q[i][7:0];
              m_in_frame = 1'b0;
              if (x == m_chk) begin
                m_hold = 1'b1; m_pv = 1'b1;
                m_psrc = m_src; m_pdst = m_dst; m_plen = 3'(m_len);
                m_data = '0;
                foreach (m_q[i]) m_data[30*i +: 30] = m_q[i];
              end else begin
                err = 1'b1; code = 3'd6;
              end
            end
          end
        end
        default: ;
      endcase
    end
    m_ev = err;
    m_ec = code;
    if (err) m_drops++;
    m_rdy_en = 1'b1;
  endtask

  task automatic compare();
    chk("flit_ready", flit_ready, m_rdy_en && !m_hold);
    chk("pkt_valid", pkt_valid, m_pv);
    chk("sat_pkt_valid", s_pkt_valid, m_pv);
    chk("err_valid", err_valid, m_ev);
    if (m_ev) chk("err_code", err_code, m_ec);
    chk("drop_count", drop_count, sat(m_drops, 65535));
    chk("drop_count_sat", s_drop_count, sat(m_drops, 3));
    if (m_pv) begin
      chk("pkt_src", pkt_src, m_psrc);
      chk("pkt_dst", pkt_dst, m_pdst);
      chk("pkt_len", pkt_len, m_plen);
      chk("pkt_data", pkt_data, m_data);
    end
  endtask

  // drive at negedge, predict, then compare just after the rising edge
  task automatic cycle(input logic [31:0] f, input logic v, input logic pr);
    flit_in = f; flit_valid = v; pkt_ready = pr;
    model_step(f, v, pr);
    @(posedge clk);
    #1;
    compare();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; flit_valid = 1'b0; pkt_ready = 1'b0; flit_in = 32'h0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_flit_ready", flit_ready, 1'b0);
    chk("rst_pkt_valid", pkt_valid, 1'b0);
    chk("rst_pkt_fields", {pkt_src, pkt_dst, pkt_len}, 19'h0);
    chk("rst_pkt_data", pkt_data, 120'h0);
    chk("rst_err", {err_valid, err_code}, 4'h0);
    chk("rst_drop_count", drop_count, 16'h0);
    rst_n = 1'b1;
    cycle(32'h0, 1'b0, 1'b0);
  endtask

  task automatic gen_frame();
    int len, r;
    logic [29:0] p[$];
    logic [29:0] pw;
    logic [7:0] x, c;
    logic [1:0] t;
    r = $urandom_range(0, 9);
    if (r < 8) len = $urandom_range(1, 4);
    else if (r == 8) len = 0;
    else len = 5;
    x = 8'h00;
    for (int i = 0; i < len; i++) begin
      pw = 30'($urandom);
      p.push_back(pw);
      x ^= pw[7:0];
    end
    c = ($urandom_range(0, 3) == 0) ? 8'($urandom) : x;
    sq.push_back(mk_head(8'($urandom), 8'($urandom), 6'(len), c));
    for (int i = 0; i < len; i++) begin
      t = (i == len - 1) ? 2'b11 : 2'b10;
      if ($urandom_range(0, 11) == 0) t = 2'($urandom);
      sq.push_back({t, p[i]});
      if ($urandom_range(0, 5) == 0) sq.push_back(mk_nope(30'($urandom)));
    end
  endtask

  logic [31:0]  hd_good, b50, ta;
  logic [119:0] exp_d;

  initial begin
    hd_good = mk_head(8'h12, 8'h34, 6'd2, 8'h5A);
    b50     = mk_body(30'h50);
    ta      = mk_tail(30'h0A);

    tbl.push_back(mk(hd_good, 1, 1, 0, 1, 0, 3'd0, 16'd0));
    tbl.push_back(mk(b50,     1, 1, 0, 1, 0, 3'd0, 16'd0));
    tbl.push_back(mk(ta,      1, 1, 1, 0, 0, 3'd0, 16'd0));
    tbl.push_back(mk(32'h0,   0, 1, 0, 1, 0, 3'd0, 16'd0));
    tbl.push_back(mk(mk_head(8'h12, 8'h34, 6'd2, 8'h00), 1, 1, 0, 1, 0, 3'd0, 16'd0));
    tbl.push_back(mk(b50,     1, 1, 0, 1, 0, 3'd0, 16'd0));
    tbl.push_back(mk(ta,      1, 1, 0, 1, 1, 3'd6, 16'd1));
    tbl.push_back(mk(32'h0,   0, 1, 0, 1, 0, 3'd0, 16'd1));
    tbl.push_back(mk(mk_head(8'h01, 8'h02, 6'd0, 8'h00), 1, 1, 0, 1, 1, 3'd1, 16'd2));
    tbl.push_back(mk(mk_head(8'h01, 8'h02, 6'd5, 8'h00), 1, 1, 0, 1, 1, 3'd1, 16'd3));
    tbl.push_back(mk(mk_body(30'h3), 1, 1, 0, 1, 1, 3'd2, 16'd4));
    tbl.push_back(mk(mk_head(8'h01, 8'h02, 6'd3, 8'h00), 1, 1, 0, 1, 0, 3'd0, 16'd4));
    tbl.push_back(mk(mk_tail(30'h1), 1, 1, 0, 1, 1, 3'd4, 16'd5));
    tbl.push_back(mk(mk_head(8'h01, 8'h02, 6'd1, 8'h00), 1, 1, 0, 1, 0, 3'd0, 16'd5));
    tbl.push_back(mk(mk_body(30'h1), 1, 1, 0, 1, 1, 3'd5, 16'd6));
    tbl.push_back(mk(mk_nope(30'h3FF), 1, 1, 0, 1, 0, 3'd0, 16'd6));
    tbl.push_back(mk(hd_good, 1, 1, 0, 1, 0, 3'd0, 16'd6));
    tbl.push_back(mk(mk_nope(30'h1), 1, 1, 0, 1, 0, 3'd0, 16'd6));
    tbl.push_back(mk(b50,     1, 1, 0, 1, 0, 3'd0, 16'd6));
    tbl.push_back(mk(mk_nope(30'h2), 1, 1, 0, 1, 0, 3'd0, 16'd6));
    tbl.push_back(mk(mk_nope(30'h3), 1, 1, 0, 1, 0, 3'd0, 16'd6));
    tbl.push_back(mk(ta,      1, 0, 1, 0, 0, 3'd0, 16'd6));
    tbl.push_back(mk(32'h0,   0, 1, 0, 1, 0, 3'd0, 16'd6));

    do_reset();

    foreach (tbl[i]) begin
      cycle(tbl[i].f, tbl[i].v, tbl[i].pr);
      chk($sformatf("tbl[%0d].pkt_valid", i), pkt_valid, tbl[i].e_pv);
      chk($sformatf("tbl[%0d].flit_ready", i), flit_ready, tbl[i].e_fr);
      chk($sformatf("tbl[%0d].err_valid", i), err_valid, tbl[i].e_ev);
      if (tbl[i].e_ev) chk($sformatf("tbl[%0d].err_code", i), err_code, tbl[i].e_ec);
      chk($sformatf("tbl[%0d].drop_count", i), drop_count, tbl[i].e_drop);
    end
    chk("sat_drop_after_6", s_drop_count, 2'd3);

    // backpressure: packet held five cycles while a HEAD waits
    cycle(hd_good, 1, 0);
    cycle(b50, 1, 0);
    cycle(ta, 1, 0);
    exp_d = {60'h0, 30'h0A, 30'h50};
    chk("bp_pkt_src", pkt_src, 8'h12);
    chk("bp_pkt_dst", pkt_dst, 8'h34);
    chk("bp_pkt_len", pkt_len, 3'd2);
    chk("bp_pkt_data", pkt_data, exp_d);
    for (int k = 0; k < 5; k++) begin
      cycle(hd_good, 1, 0);
      chk("bp_hold_valid", pkt_valid, 1'b1);
      chk("bp_hold_ready", flit_ready, 1'b0);
      chk("bp_hold_data", pkt_data, exp_d);
    end
    cycle(hd_good, 1, 1);
    chk("bp_release_valid", pkt_valid, 1'b0);
    chk("bp_release_ready", flit_ready, 1'b1);
    cycle(hd_good, 1, 1);
    cycle(b50, 1, 1);
    cycle(ta, 1, 1);
    chk("bp_second_pkt", pkt_valid, 1'b1);
    cycle(32'h0, 0, 1);

    // resync on an unexpected HEAD
    cycle(mk_head(8'h01, 8'h02, 6'd3, 8'h00), 1, 1);
    cycle(mk_body(30'h9), 1, 1);
    cycle(mk_head(8'hAB, 8'hCD, 6'd1, 8'h07), 1, 1);
    chk("resync_err_valid", err_valid, 1'b1);
    chk("resync_err_code", err_code, 3'd3);
    cycle(mk_tail(30'h7), 1, 1);
    chk("resync_pkt_valid", pkt_valid, 1'b1);
    chk("resync_pkt_len", pkt_len, 3'd1);
    chk("resync_pkt_data", pkt_data, 120'h7);
    chk("resync_no_err", err_valid, 1'b0);
    cycle(32'h0, 0, 1);

    // resync HEAD with bad length reports code 3 only
    cycle(mk_head(8'h01, 8'h02, 6'd2, 8'h00), 1, 1);
    cycle(mk_head(8'h01, 8'h02, 6'd0, 8'h00), 1, 1);
    chk("resync_badlen_code", err_code, 3'd3);
    cycle(mk_body(30'h1), 1, 1);
    chk("after_badlen_orphan", err_code, 3'd2);

    // asynchronous reset mid-frame
    cycle(hd_good, 1, 1);
    cycle(b50, 1, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ready", flit_ready, 1'b0);
    chk("async_rst_valid", pkt_valid, 1'b0);
    chk("async_rst_drop", drop_count, 16'h0);
    chk("async_rst_drop_sat", s_drop_count, 2'd0);
    do_reset();

    // asynchronous reset while holding a packet
    cycle(hd_good, 1, 0);
    cycle(b50, 1, 0);
    cycle(ta, 1, 0);
    cycle(32'h0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_hold_rst_valid", pkt_valid, 1'b0);
    chk("async_hold_rst_data", pkt_data, 120'h0);
    do_reset();

    // randomized frames with corruption, gaps and backpressure
    for (int n = 0; n < 3000; n++) begin
      if (sq.size() == 0) gen_frame();
      cycle(sq[0], ($urandom_range(0, 4) != 0), ($urandom_range(0, 2) != 0));
      if (m_last_acc) void'(sq.pop_front());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
